// File: rtl/fp16_pkg.sv
// Shared fp16 constants, flag indices and the stage-1 to stage-2 payload type.
package fp16_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned FRAC_W   = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;
  localparam int unsigned NORM_W   = 21;

  localparam logic [15:0] QNAN = 16'h7E00;

  localparam int unsigned FLAG_OVF  = 3;
  localparam int unsigned FLAG_UNF  = 2;
  localparam int unsigned FLAG_INX  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  typedef struct packed {
    logic              sign;
    logic signed [6:0] e;
    logic [NORM_W-1:0] mant;
    logic              sticky;
    logic              bypass;
    logic [15:0]       word;
    logic [3:0]        flags;
  } s1_t;

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero counter over the 21-bit hidden+fraction+guard field; all-zero yields 21.
module fp16_lzc
  import fp16_pkg::*;
(
  input  logic [NORM_W-1:0] vec,
  output logic [4:0]        cnt
);

  logic found;

  always_comb begin
    cnt   = 5'(NORM_W);
    found = 1'b0;
    for (int unsigned i = 0; i < NORM_W; i++) begin
      if (!found && vec[NORM_W-1-i]) begin
        cnt   = 5'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_norm_round.sv
// Two-stage normalise / round-to-nearest-even stage producing packed binary16 plus flags.
module fp16_norm_round
  import fp16_pkg::*;
#(
  parameter int unsigned MANT_W = 22,
  parameter int unsigned FTZ    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [4:0]        in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic [3:0]        out_flags
);

  s1_t               s1_d, s1_q;
  logic              s1_valid;
  logic              s2_ready;
  logic [4:0]        lz;
  logic [NORM_W-1:0] shifted;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_ready;

  fp16_lzc u_lzc (
    .vec (in_mant[NORM_W-1:0]),
    .cnt (lz)
  );

  // Stage 1: normalise; specials, zero and flushed underflow become a bypass word.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    shifted   = in_mant[NORM_W-1:0] << lz;
    if (in_exp == 5'(EXP_MAX)) begin
      s1_d.bypass = 1'b1;
      s1_d.word   = (in_mant[19:10] != '0) ? QNAN : {in_sign, 5'h1F, 10'h000};
    end else if (in_mant == '0) begin
      s1_d.bypass           = 1'b1;
      s1_d.word             = {in_sign, 15'h0000};
      s1_d.flags[FLAG_ZERO] = 1'b1;
    end else begin
      if (in_mant[21]) begin
        s1_d.mant   = in_mant[21:1];
        s1_d.sticky = in_mant[0];
        s1_d.e      = $signed({2'b00, in_exp}) + 7'sd1;
      end else begin
        s1_d.mant = shifted;
        s1_d.e    = $signed({2'b00, in_exp}) - $signed({2'b00, lz});
      end
      if ((FTZ != 0) && (s1_d.e < 7'sd1)) begin
        s1_d.bypass           = 1'b1;
        s1_d.word             = {in_sign, 15'h0000};
        s1_d.flags[FLAG_UNF]  = 1'b1;
        s1_d.flags[FLAG_INX]  = 1'b1;
        s1_d.flags[FLAG_ZERO] = 1'b1;
      end
    end
  end

  logic              guard, sticky2, rnd_up;
  logic [10:0]       frac_rnd;
  logic signed [6:0] e2;
  logic [15:0]       res;
  logic [3:0]        flg;
  logic              unused_hidden;

  assign unused_hidden = s1_q.mant[20];

  // Stage 2: RNE; a fraction carry-out bumps the exponent and may overflow.
  always_comb begin
    guard    = s1_q.mant[9];
    sticky2  = (|s1_q.mant[8:0]) | s1_q.sticky;
    rnd_up   = guard & (sticky2 | s1_q.mant[10]);
    frac_rnd = {1'b0, s1_q.mant[19:10]} + {10'd0, rnd_up};
    e2       = s1_q.e + (frac_rnd[10] ? 7'sd1 : 7'sd0);
    res      = '0;
    flg      = '0;
    if (s1_q.bypass) begin
      res = s1_q.word;
      flg = s1_q.flags;
    end else if (e2 >= $signed(7'(EXP_MAX))) begin
      res           = {s1_q.sign, 5'h1F, 10'h000};
      flg[FLAG_OVF] = 1'b1;
      flg[FLAG_INX] = 1'b1;
    end else begin
      res           = {s1_q.sign, e2[4:0], frac_rnd[9:0]};
      flg[FLAG_INX] = guard | sticky2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res;
          out_flags  <= flg;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_norm_round.sv
// Scoreboard bench for fp16_norm_round: directed vectors, backpressure, reset and random traffic.
module tb_fp16_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [21:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [3:0]  out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] cur_exp = '0;
  logic [19:0] q[$];
  logic        stall_prev = 1'b0;
  logic [19:0] stall_val = '0;

  always #5 clk = ~clk;

  fp16_norm_round #(.MANT_W(22), .FTZ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp_v, $time);
    end
  endtask

  // Reference: bit-serial normalisation and explicit RNE on the fraction.
  function automatic logic [19:0] model(input logic s, input logic [4:0] ex, input logic [21:0] mt);
    int          e;
    logic [21:0] m;
    logic        st, g;
    logic [9:0]  f;
    if (ex == 5'd31) return {((mt[19:10] != 0) ? 16'h7E00 : {s, 5'h1F, 10'h000}), 4'h0};
    if (mt == 0) return {s, 15'h0, 4'b0001};
    e  = int'(ex);
    m  = mt;
    st = 1'b0;
    if (m[21]) begin
      st = m[0];
      m  = m >> 1;
      e++;
    end else begin
      while (!m[20]) begin
        m = m << 1;
        e--;
      end
    end
    if (e < 1) return {s, 15'h0, 4'b0111};
    g  = m[9];
    st = st | (m[8:0] != 0);
    f  = m[19:10];
    if (g && (st || f[0])) begin
      if (f == 10'h3FF) begin
        f = '0;
        e++;
      end else begin
        f = f + 10'd1;
      end
    end
    if (e >= 31) return {s, 5'h1F, 10'h000, 4'b1010};
    return {s, 5'(e), f, 2'b00, (g | st), 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        check_eq("stall_valid", 20'(out_valid), 20'd1);
        check_eq("stall_hold", {out_result, out_flags}, stall_val);
      end
      if (out_valid && out_ready) begin
        check_eq("out_has_expect", 20'(q.size() != 0), 20'd1);
        if (q.size() != 0) check_eq("result", {out_result, out_flags}, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_result, out_flags};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic s, input logic [4:0] e, input logic [21:0] m, input logic [19:0] exp_v);
    int   waits = 0;
    logic acc   = 1'b0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    cur_exp  = exp_v;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!acc) check_eq("send_timeout", 20'(waits), 20'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 50) check_eq("drain_timeout", 20'(q.size()), 20'd0);
  endtask

  typedef struct {
    logic        s;
    logic [4:0]  e;
    logic [21:0] m;
    logic [19:0] x;
  } vec_t;

  vec_t dir[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic drv_done;

    dir[0] = '{1'b0, 5'd15, 22'h200000, {16'h4000, 4'b0000}};
    dir[1] = '{1'b0, 5'd15, 22'h040000, {16'h3400, 4'b0000}};
    dir[2] = '{1'b1, 5'd1,  22'h040000, {16'h8000, 4'b0111}};
    dir[3] = '{1'b0, 5'd15, 22'h100200, {16'h3C00, 4'b0010}};
    dir[4] = '{1'b0, 5'd15, 22'h100600, {16'h3C02, 4'b0010}};
    dir[5] = '{1'b0, 5'd30, 22'h3FFFFF, {16'h7C00, 4'b1010}};
    dir[6] = '{1'b0, 5'd31, 22'h100400, {16'h7E00, 4'b0000}};
    dir[7] = '{1'b1, 5'd10, 22'h000000, {16'h8000, 4'b0001}};
    dir[8] = '{1'b1, 5'd31, 22'h000000, {16'hFC00, 4'b0000}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", 20'(out_valid), 20'd0);
    check_eq("rst_out_result", 20'(out_result), 20'd0);
    check_eq("rst_out_flags", 20'(out_flags), 20'd0);
    check_eq("rst_in_ready", 20'(in_ready), 20'd1);

    // Latency of a single beat with the consumer always ready.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sign  = dir[0].s;
    in_exp   = dir[0].e;
    in_mant  = dir[0].m;
    cur_exp  = dir[0].x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 20'(lat), 20'd2);
    drain();

    for (int i = 1; i < 9; i++) send(dir[i].s, dir[i].e, dir[i].m, dir[i].x);
    drain();

    // Backpressure: consumer stalls for the first three edges of a four-beat stream.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i < 5; i++) send(dir[i].s, dir[i].e, dir[i].m, dir[i].x);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("in_ready_full", 20'(in_ready), 20'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(dir[1].s, dir[1].e, dir[1].m, dir[1].x);
    send(dir[3].s, dir[3].e, dir[3].m, dir[3].x);
    rst = 1'b0;
    #1;
    check_eq("midrst_out_valid", 20'(out_valid), 20'd0);
    check_eq("midrst_out_result", 20'(out_result), 20'd0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("no_emit_after_rst", 20'(out_valid), 20'd0);
    end
    send(dir[4].s, dir[4].e, dir[4].m, dir[4].x);
    drain();

    // Random traffic with a randomly stalling consumer.
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic        s;
          logic [4:0]  e;
          logic [21:0] m;
          s = 1'($urandom_range(0, 1));
          e = 5'($urandom_range(0, 31));
          m = 22'($urandom) >> $urandom_range(0, 21);
          send(s, e, m, model(s, e, m));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
